// File: rtl/alu_result_wb_if.sv
// rtl/alu_result_wb_if.sv - ALU result / register write-back signal bundle
//
// Purpose: groups every non-clock, non-reset signal of alu_result_wb.
// Ports (signals):
//   aluResult, aluResultValid      ALU result and its load strobe
//   memRdata, memRvalid            memory read data and its valid pulse
//   pcPlus4, imm                   link value and immediate
//   wbReq, wbSrc, loadSize,        write-back request and its attributes
//   loadUnsigned, rd
//   aluOut                         registered ALU result / memory address
//   regWe, regWaddr, regWdata      register-file write port
//   busy, done                     status
// Modports: slave = write-back unit side, master = core/driver side.
interface alu_result_wb_if #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
);
  logic [XLEN-1:0]      aluResult;
  logic                 aluResultValid;
  logic [XLEN-1:0]      memRdata;
  logic                 memRvalid;
  logic [XLEN-1:0]      pcPlus4;
  logic [XLEN-1:0]      imm;
  logic                 wbReq;
  logic [1:0]           wbSrc;
  logic [1:0]           loadSize;
  logic                 loadUnsigned;
  logic [REGADDR_W-1:0] rd;
  logic [XLEN-1:0]      aluOut;
  logic                 regWe;
  logic [REGADDR_W-1:0] regWaddr;
  logic [XLEN-1:0]      regWdata;
  logic                 busy;
  logic                 done;

  modport slave (
    input  aluResult, aluResultValid, memRdata, memRvalid, pcPlus4, imm,
           wbReq, wbSrc, loadSize, loadUnsigned, rd,
    output aluOut, regWe, regWaddr, regWdata, busy, done
  );

  modport master (
    output aluResult, aluResultValid, memRdata, memRvalid, pcPlus4, imm,
           wbReq, wbSrc, loadSize, loadUnsigned, rd,
    input  aluOut, regWe, regWaddr, regWdata, busy, done
  );
endinterface

// File: rtl/alu_result_wb.sv
// rtl/alu_result_wb.sv - ALUOut register and register-file write-back selection
//
// Purpose: holds the ALU result in aluOut, selects the write-back source
// (aluOut, load data, pcPlus4, imm), waits for load data when needed,
// extracts/extends byte, half or word loads and issues a one-cycle write.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    alu_result_wb_if.slave (see interface file for signal list)
module alu_result_wb #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_result_wb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [XLEN-1:0]      alu_out_q;
  logic [XLEN-1:0]      wdata_q;
  logic [REGADDR_W-1:0] waddr_q;
  logic [REGADDR_W-1:0] rd_q;
  logic [1:0]           size_q;
  logic [1:0]           off_q;
  logic                 unsigned_q;
  logic                 capture;
  logic                 mem_accept;
  logic [XLEN-1:0]      src_data;
  logic [XLEN-1:0]      load_data;
  logic [7:0]           load_byte;
  logic [15:0]          load_half;

  // aluOut loads whenever the ALU says so, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
    end else if (bus.aluResultValid) begin
      alu_out_q <= bus.aluResult;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    mem_accept = 1'b0;
    bus.regWe  = 1'b0;
    bus.done   = 1'b0;
    bus.busy   = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.wbReq) begin
          capture    = 1'b1;
          state_next = (bus.wbSrc == 2'b01) ? WAIT_MEM : WRITE;
        end
      end
      WAIT_MEM: begin
        if (bus.memRvalid) begin
          mem_accept = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        bus.regWe  = (rd_q != '0);
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Non-load sources, sampled on the wbReq edge (aluOut before any update).
  always_comb begin
    src_data = alu_out_q;
    case (bus.wbSrc)
      2'b10:   src_data = bus.pcPlus4;
      2'b11:   src_data = bus.imm;
      default: src_data = alu_out_q;
    endcase
  end

  // Little-endian lane extraction from the word-aligned read data.
  always_comb begin
    load_byte = bus.memRdata[7:0];
    case (off_q)
      2'd1:    load_byte = bus.memRdata[15:8];
      2'd2:    load_byte = bus.memRdata[23:16];
      2'd3:    load_byte = bus.memRdata[31:24];
      default: load_byte = bus.memRdata[7:0];
    endcase
    load_half = off_q[1] ? bus.memRdata[31:16] : bus.memRdata[15:0];
    case (size_q)
      2'b00:   load_data = {{(XLEN-8){~unsigned_q & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{(XLEN-16){~unsigned_q & load_half[15]}}, load_half};
      default: load_data = bus.memRdata;
    endcase
  end

  // waddr_q/wdata_q only change on entry to WRITE, so they hold their last
  // values while a load is outstanding and between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      size_q     <= '0;
      off_q      <= '0;
      unsigned_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else if (capture) begin
      rd_q       <= bus.rd;
      size_q     <= bus.loadSize;
      off_q      <= alu_out_q[1:0];
      unsigned_q <= bus.loadUnsigned;
      if (bus.wbSrc != 2'b01) begin
        waddr_q <= bus.rd;
        wdata_q <= src_data;
      end
    end else if (mem_accept) begin
      waddr_q <= rd_q;
      wdata_q <= load_data;
    end
  end

  assign bus.aluOut   = alu_out_q;
  assign bus.regWaddr = waddr_q;
  assign bus.regWdata = wdata_q;

endmodule

// File: tb/tb_alu_result_wb.sv
// tb/tb_alu_result_wb.sv - self-checking bench for alu_result_wb
module tb_alu_result_wb;

  logic clk;
  logic rst_n;

  alu_result_wb_if #(.XLEN(32), .REGADDR_W(5)) bus ();

  alu_result_wb #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [31:0] imm;
    int          delay;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  int n_vec;
  int n_err;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: write-back value from the rules, using plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] src, input logic [31:0] aluv,
                                        input logic [31:0] memv, input logic [31:0] pc,
                                        input logic [31:0] immv, input logic [1:0] size,
                                        input logic uns);
    longint x;
    int off;
    off = int'(aluv % 4);
    if (src == 2'd0) return aluv;
    if (src == 2'd2) return pc;
    if (src == 2'd3) return immv;
    if (size == 2'd0) begin
      x = longint'((memv >> (8 * off)) % 256);
      if (!uns && x >= 128) x = x - 256;
    end else if (size == 2'd1) begin
      x = longint'((memv >> ((off >= 2) ? 16 : 0)) % 65536);
      if (!uns && x >= 32768) x = x - 65536;
    end else begin
      x = longint'(memv);
    end
    return x[31:0];
  endfunction

  task automatic run_wb(input vec_t v);
    bus.aluResult      = v.alu;
    bus.aluResultValid = 1'b1;
    tick();
    bus.aluResultValid = 1'b0;
    bus.aluResult      = $urandom;
    chk({v.name, ".aluOut"}, bus.aluOut, v.alu);
    bus.wbReq        = 1'b1;
    bus.wbSrc        = v.src;
    bus.rd           = v.rd;
    bus.loadSize     = v.size;
    bus.loadUnsigned = v.uns;
    bus.pcPlus4      = v.pc;
    bus.imm          = v.imm;
    tick();
    bus.wbReq        = 1'b0;
    bus.pcPlus4      = $urandom;
    bus.imm          = $urandom;
    bus.rd           = 5'($urandom);
    bus.loadSize     = 2'($urandom);
    bus.loadUnsigned = 1'($urandom);
    if (v.src == 2'b01) begin
      chk({v.name, ".busy_wait"}, 32'(bus.busy), 32'd1);
      for (int i = 0; i < v.delay; i++) begin
        tick();
        chk({v.name, ".busy_wait"}, 32'(bus.busy), 32'd1);
        chk({v.name, ".we_wait"}, 32'(bus.regWe), 32'd0);
      end
      bus.memRdata  = v.mem;
      bus.memRvalid = 1'b1;
      tick();
      bus.memRvalid = 1'b0;
      bus.memRdata  = $urandom;
    end
    chk({v.name, ".regWe"}, 32'(bus.regWe), 32'(v.exp_we));
    chk({v.name, ".regWaddr"}, 32'(bus.regWaddr), 32'(v.rd));
    chk({v.name, ".regWdata"}, bus.regWdata, v.exp_data);
    chk({v.name, ".done"}, 32'(bus.done), 32'd1);
    chk({v.name, ".busy_write"}, 32'(bus.busy), 32'd1);
    tick();
    chk({v.name, ".we_after"}, 32'(bus.regWe), 32'd0);
    chk({v.name, ".done_after"}, 32'(bus.done), 32'd0);
    chk({v.name, ".busy_after"}, 32'(bus.busy), 32'd0);
    chk({v.name, ".waddr_hold"}, 32'(bus.regWaddr), 32'(v.rd));
    chk({v.name, ".wdata_hold"}, bus.regWdata, v.exp_data);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //           name       src    rd     size   uns   alu           mem           pc            imm           dly we    data
    vecs[0]  = '{"alu",     2'd0,  5'd5,  2'd0,  1'b0, 32'h0000_1234, 32'h0,        32'h0,        32'h0,        0, 1'b1, 32'h0000_1234};
    vecs[1]  = '{"lb_s",    2'd1,  5'd7,  2'd0,  1'b0, 32'h0000_0102, 32'h1280_FF34, 32'h0,        32'h0,        3, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{"lhu",     2'd1,  5'd8,  2'd1,  1'b1, 32'h0000_0102, 32'hBEEF_0001, 32'h0,        32'h0,        1, 1'b1, 32'h0000_BEEF};
    vecs[3]  = '{"link",    2'd2,  5'd31, 2'd0,  1'b0, 32'h0000_0000, 32'h0,        32'h0040_0008, 32'h0,        0, 1'b1, 32'h0040_0008};
    vecs[4]  = '{"link_x0", 2'd2,  5'd0,  2'd0,  1'b0, 32'h0000_0004, 32'h0,        32'h0040_0010, 32'h0,        0, 1'b0, 32'h0040_0010};
    vecs[5]  = '{"imm",     2'd3,  5'd3,  2'd0,  1'b0, 32'h0000_0000, 32'h0,        32'h0,        32'hDEAD_0000, 0, 1'b1, 32'hDEAD_0000};
    vecs[6]  = '{"lw",      2'd1,  5'd12, 2'd2,  1'b0, 32'h0000_2003, 32'h8000_0001, 32'h0,        32'h0,        0, 1'b1, 32'h8000_0001};
    vecs[7]  = '{"lw_sz3",  2'd1,  5'd13, 2'd3,  1'b0, 32'h0000_2001, 32'hCAFE_F00D, 32'h0,        32'h0,        2, 1'b1, 32'hCAFE_F00D};
    vecs[8]  = '{"lbu_b3",  2'd1,  5'd14, 2'd0,  1'b1, 32'h0000_3003, 32'hAB00_0000, 32'h0,        32'h0,        0, 1'b1, 32'h0000_00AB};
    vecs[9]  = '{"lh_s0",   2'd1,  5'd15, 2'd1,  1'b0, 32'h0000_3000, 32'h1234_8001, 32'h0,        32'h0,        1, 1'b1, 32'hFFFF_8001};
    vecs[10] = '{"lh_off3", 2'd1,  5'd16, 2'd1,  1'b0, 32'h0000_3003, 32'h7FFE_9999, 32'h0,        32'h0,        0, 1'b1, 32'h0000_7FFE};
    vecs[11] = '{"lb_x0",   2'd1,  5'd0,  2'd0,  1'b0, 32'h0000_0001, 32'h0000_8000, 32'h0,        32'h0,        1, 1'b0, 32'hFFFF_FF80};

    bus.aluResult = '0; bus.aluResultValid = 1'b0; bus.memRdata = '0; bus.memRvalid = 1'b0;
    bus.pcPlus4 = '0; bus.imm = '0; bus.wbReq = 1'b0; bus.wbSrc = '0; bus.loadSize = '0;
    bus.loadUnsigned = 1'b0; bus.rd = '0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst.aluOut", bus.aluOut, 32'h0);
    chk("rst.regWe", 32'(bus.regWe), 32'd0);
    chk("rst.regWaddr", 32'(bus.regWaddr), 32'd0);
    chk("rst.regWdata", bus.regWdata, 32'h0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_wb(vecs[i]);

    // Second wbReq during WAIT_MEM and during WRITE must be dropped.
    bus.aluResult = 32'h0000_0102; bus.aluResultValid = 1'b1; tick(); bus.aluResultValid = 1'b0;
    bus.wbReq = 1'b1; bus.wbSrc = 2'b01; bus.rd = 5'd7; bus.loadSize = 2'b00; bus.loadUnsigned = 1'b0;
    tick();
    bus.wbReq = 1'b1; bus.wbSrc = 2'b00; bus.rd = 5'd9;
    tick();
    bus.wbReq = 1'b0;
    chk("coll.busy", 32'(bus.busy), 32'd1);
    bus.memRdata = 32'h1280_FF34; bus.memRvalid = 1'b1; bus.wbReq = 1'b1;
    tick();
    bus.memRvalid = 1'b0;
    chk("coll.regWe", 32'(bus.regWe), 32'd1);
    chk("coll.regWaddr", 32'(bus.regWaddr), 32'd7);
    chk("coll.regWdata", bus.regWdata, 32'hFFFF_FF80);
    tick();
    bus.wbReq = 1'b0;
    chk("coll.idle", 32'(bus.busy), 32'd0);
    chk("coll.no_second_we", 32'(bus.regWe), 32'd0);
    tick();
    chk("coll.still_idle", 32'(bus.busy), 32'd0);

    // memRvalid while idle.
    bus.memRdata = 32'h5555_5555; bus.memRvalid = 1'b1;
    tick();
    bus.memRvalid = 1'b0;
    chk("idle_rvalid.we", 32'(bus.regWe), 32'd0);
    chk("idle_rvalid.busy", 32'(bus.busy), 32'd0);
    tick();
    chk("idle_rvalid.done", 32'(bus.done), 32'd0);

    // Reset in WAIT_MEM.
    bus.aluResult = 32'h0000_0040; bus.aluResultValid = 1'b1; tick(); bus.aluResultValid = 1'b0;
    bus.wbReq = 1'b1; bus.wbSrc = 2'b01; bus.rd = 5'd20; bus.loadSize = 2'b10;
    tick();
    bus.wbReq = 1'b0;
    tick();
    chk("rstmid.busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.aluOut", bus.aluOut, 32'h0);
    chk("rstmid.regWe", 32'(bus.regWe), 32'd0);
    chk("rstmid.regWaddr", 32'(bus.regWaddr), 32'd0);
    chk("rstmid.regWdata", bus.regWdata, 32'h0);
    chk("rstmid.done", 32'(bus.done), 32'd0);
    chk("rstmid.busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.memRdata = 32'h1111_2222; bus.memRvalid = 1'b1;
    tick();
    bus.memRvalid = 1'b0;
    chk("rstmid.we_after", 32'(bus.regWe), 32'd0);
    chk("rstmid.done_after", 32'(bus.done), 32'd0);
    chk("rstmid.busy_after", 32'(bus.busy), 32'd0);
    tick();
    chk("rstmid.we_after2", 32'(bus.regWe), 32'd0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.name  = $sformatf("rand%0d", i);
      v.src   = 2'($urandom);
      v.rd    = 5'($urandom);
      v.size  = 2'($urandom);
      v.uns   = 1'($urandom);
      v.alu   = $urandom;
      v.mem   = $urandom;
      v.pc    = $urandom;
      v.imm   = $urandom;
      v.delay = int'($urandom_range(0, 3));
      v.exp_we   = (v.rd != 5'd0);
      v.exp_data = model(v.src, v.alu, v.mem, v.pc, v.imm, v.size, v.uns);
      run_wb(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_wb.md
Name: alu_result_wb

Overview:
- Output-side counterpart of the ALU operand selection in the multi-cycle MIPS→RISC-V core.
- Holds the ALU result in the ALUOut register and selects the register-file write-back source: ALU result, load data, link address or immediate.
- For loads, waits on the memory read-valid handshake, then extracts and sign- or zero-extends the byte, half or word.
- Issues a single-cycle register-file write strobe.

Parameters:
- XLEN, 32, datapath width.
- REGADDR_W, 5, register index width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- aluResult  input  XLEN  combinational ALU output.
- aluResultValid  input  1  load aluResult into aluOut this cycle.
- memRdata  input  XLEN  memory read data, word-aligned, little-endian.
- memRvalid  input  1  memRdata valid, single-cycle pulse.
- pcPlus4  input  XLEN  link value.
- imm  input  XLEN  immediate value (lui/auipc path).
- wbReq  input  1  start write-back, single-cycle pulse.
- wbSrc  input  2  00 aluOut, 01 load, 10 pcPlus4, 11 imm.
- loadSize  input  2  00 byte, 01 half, 10 word; 11 treated as word.
- loadUnsigned  input  1  zero-extend when 1, sign-extend when 0.
- rd  input  REGADDR_W  destination register.
- aluOut  output  XLEN  registered ALU result; also the memory address.
- regWe  output  1  register-file write enable.
- regWaddr  output  REGADDR_W  register-file write address.
- regWdata  output  XLEN  register-file write data.
- busy  output  1  high in WAIT_MEM and WRITE.
- done  output  1  one-cycle pulse when write-back completes.

Behaviour:
- Reset (rst_n low, asynchronous): aluOut=0, regWe=0, regWaddr=0, regWdata=0, done=0, state=IDLE, all captured fields=0.
- aluOut register:
  - Loads aluResult on any edge where aluResultValid=1, in every state.
  - Otherwise holds its value.
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE:
  - On wbReq, capture rd, wbSrc, loadSize, loadUnsigned and byteOff = aluOut[1:0], using the values before any same-edge aluOut update.
  - If wbSrc=01, go to WAIT_MEM.
  - For any other source, latch the write data from aluOut, pcPlus4 or imm as sampled on the wbReq edge, and go to WRITE.
- WAIT_MEM:
  - Stay until memRvalid=1.
  - On memRvalid, latch the extracted load data and go to WRITE.
- WRITE:
  - regWe = (captured rd != 0); regWaddr = captured rd; regWdata = latched data; done = 1.
  - Next state is IDLE.
  - regWe and done are high for exactly one cycle.
- Load extraction:
  - Byte: memRdata[8*byteOff+7 : 8*byteOff].
  - Half: byteOff[1] selects bits [15:0] (0) or [31:16] (1); byteOff[0] ignored.
  - Word: full word; byteOff ignored.
  - Extension is sign or zero per loadUnsigned.
- Latency:
  - Non-load: wbReq on edge N gives regWe high in the cycle after edge N (1 cycle).
  - Load: memRvalid on edge M gives regWe high in the cycle after edge M.
- Boundary conditions:
  - wbReq while busy: ignored, with no capture and no state change.
  - memRvalid in IDLE or WRITE: ignored.
  - rd=0: regWe stays 0, but done still pulses and the FSM still passes through WRITE.
  - regWaddr and regWdata hold their last values outside WRITE.
  - rst_n asserted in WAIT_MEM or WRITE: immediate return to IDLE; no regWe or done is produced afterwards for that request.
  - busy = (state != IDLE).

Test Plan:
- ALU write-back:
  - Stimulus: aluResultValid with aluResult=0x0000_1234; next cycle wbReq with wbSrc=00, rd=5.
  - Response: one cycle later regWe=1, regWaddr=5, regWdata=0x0000_1234, done=1; the following cycle regWe=0.
- Signed byte load:
  - Stimulus: aluOut=0x0000_0102 (byteOff=2); wbReq with wbSrc=01, loadSize=00, loadUnsigned=0, rd=7; after 3 idle cycles, memRvalid with memRdata=0x1280_FF34.
  - Response: busy=1 throughout the wait; regWe one cycle after memRvalid with regWdata=0xFFFF_FF80.
- Unsigned half load:
  - Stimulus: byteOff=2, loadSize=01, loadUnsigned=1, memRdata=0xBEEF_0001.
  - Response: regWdata=0x0000_BEEF.
- Link and x0:
  - Stimulus: wbSrc=10, pcPlus4=0x0040_0008, rd=31.
  - Response: regWdata=0x0040_0008.
  - Stimulus: repeat with rd=0.
  - Response: regWe stays 0 and done pulses.
- Collisions:
  - Stimulus: a second wbReq (rd=9) during WAIT_MEM.
  - Response: ignored; the write goes to the original rd.
  - Stimulus: memRvalid in IDLE.
  - Response: no regWe.
- Reset mid-load:
  - Stimulus: drop rst_n in WAIT_MEM, release it, then pulse memRvalid.
  - Response: all outputs 0, busy=0, no regWe.
